// File: rtl/issue_fifo_drain.sv
// Issue FIFO consumer: pops scheduled {command, addr, bank} entries and drives
// the DDR command/address pins, holding off the next pop until the timing gap expires.
module issue_fifo_drain #(
    parameter int ROW_W   = 14,
    parameter int COL_W   = 10,
    parameter int BA_W    = 3,
    parameter int CMD_W   = 4,
    parameter int GAP_ACT = 4,
    parameter int GAP_RW  = 2,
    parameter int GAP_PRE = 4,
    parameter int GAP_REF = 40
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           issue_en,
    input  logic                           fifo_empty,
    input  logic [CMD_W+COL_W+ROW_W+BA_W-1:0] fifo_data,
    output logic                           fifo_ren,
    output logic                           ddr_cs_n,
    output logic                           ddr_ras_n,
    output logic                           ddr_cas_n,
    output logic                           ddr_we_n,
    output logic [ROW_W-1:0]               ddr_addr,
    output logic [BA_W-1:0]                ddr_ba,
    output logic                           issue_valid,
    output logic                           busy,
    output logic                           err_illegal
);
    localparam int DW = CMD_W + COL_W + ROW_W + BA_W;
    localparam int GW = 6;

    localparam logic [CMD_W-1:0] CMD_NOP   = CMD_W'(0);
    localparam logic [CMD_W-1:0] CMD_ACT   = CMD_W'(1);
    localparam logic [CMD_W-1:0] CMD_READ  = CMD_W'(2);
    localparam logic [CMD_W-1:0] CMD_WRITE = CMD_W'(3);
    localparam logic [CMD_W-1:0] CMD_PRE   = CMD_W'(4);
    localparam logic [CMD_W-1:0] CMD_REF   = CMD_W'(5);

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] PINS_NOP   = 4'b0111;
    localparam logic [3:0] PINS_ACT   = 4'b0011;
    localparam logic [3:0] PINS_READ  = 4'b0101;
    localparam logic [3:0] PINS_WRITE = 4'b0100;
    localparam logic [3:0] PINS_PRE   = 4'b0010;
    localparam logic [3:0] PINS_REF   = 4'b0001;

    // Column accesses never carry auto-precharge, so A10 is always cleared.
    localparam logic [ROW_W-1:0] A10_CLR = ~(ROW_W'(1) << 10);

    typedef enum logic {IDLE, GAP} state_t;

    state_t            state_reg, state_next;
    logic [GW-1:0]     gap_reg, gap_next;
    logic [3:0]        pins_reg, pins_next;
    logic [ROW_W-1:0]  addr_reg, addr_next;
    logic [BA_W-1:0]   ba_reg, ba_next;
    logic              valid_reg, valid_next;
    logic              err_reg, err_next;

    logic [CMD_W-1:0]  head_cmd;
    logic [ROW_W-1:0]  head_row;
    logic [COL_W-1:0]  head_col;
    logic [BA_W-1:0]   head_bank;

    assign head_cmd  = fifo_data[DW-1 -: CMD_W];
    assign head_row  = fifo_data[BA_W+COL_W +: ROW_W];
    assign head_col  = fifo_data[BA_W +: COL_W];
    assign head_bank = fifo_data[BA_W-1:0];

    // Gated by rst_n so no pop can be requested while the block is held in reset.
    assign fifo_ren = rst_n & issue_en & ~fifo_empty & (state_reg == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            gap_reg   <= '0;
            pins_reg  <= PINS_NOP;
            addr_reg  <= '0;
            ba_reg    <= '0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            gap_reg   <= gap_next;
            pins_reg  <= pins_next;
            addr_reg  <= addr_next;
            ba_reg    <= ba_next;
            valid_reg <= valid_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        gap_next = (gap_reg != '0) ? gap_reg - GW'(1) : '0;
        if (fifo_ren) begin
            unique case (head_cmd)
                CMD_ACT:             gap_next = GW'(GAP_ACT - 1);
                CMD_READ, CMD_WRITE: gap_next = GW'(GAP_RW - 1);
                CMD_PRE:             gap_next = GW'(GAP_PRE - 1);
                CMD_REF:             gap_next = GW'(GAP_REF - 1);
                default:             gap_next = '0;
            endcase
        end
        state_next = (gap_next != '0) ? GAP : IDLE;
    end

    always_comb begin
        pins_next  = PINS_NOP;
        addr_next  = '0;
        ba_next    = '0;
        valid_next = 1'b0;
        err_next   = err_reg;
        if (fifo_ren) begin
            unique case (head_cmd)
                CMD_NOP: ;
                CMD_ACT: begin
                    pins_next  = PINS_ACT;
                    addr_next  = head_row;
                    ba_next    = head_bank;
                    valid_next = 1'b1;
                end
                CMD_READ, CMD_WRITE: begin
                    pins_next  = (head_cmd == CMD_READ) ? PINS_READ : PINS_WRITE;
                    addr_next  = ROW_W'(head_col) & A10_CLR;
                    ba_next    = head_bank;
                    valid_next = 1'b1;
                end
                CMD_PRE: begin
                    pins_next  = PINS_PRE;
                    ba_next    = head_bank;
                    valid_next = 1'b1;
                end
                CMD_REF: begin
                    pins_next  = PINS_REF;
                    valid_next = 1'b1;
                end
                default: err_next = 1'b1;
            endcase
        end
    end

    assign {ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n} = pins_reg;
    assign ddr_addr    = addr_reg;
    assign ddr_ba      = ba_reg;
    assign issue_valid = valid_reg;
    assign busy        = (state_reg == GAP);
    assign err_illegal = err_reg;
endmodule

// File: tb/tb_issue_fifo_drain.sv
// Bench for issue_fifo_drain: directed scenarios then random traffic, checked against
// a timestamp-based model (earliest-next-issue cycle) and a queue standing in for the FIFO.
module tb_issue_fifo_drain;
    localparam int ROW_W = 14, COL_W = 10, BA_W = 3, CMD_W = 4;
    localparam int DW = CMD_W + COL_W + ROW_W + BA_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             issue_en = 1'b0;
    logic             fifo_empty = 1'b1;
    logic [DW-1:0]    fifo_data = '0;
    logic             fifo_ren;
    logic             ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n;
    logic [ROW_W-1:0] ddr_addr;
    logic [BA_W-1:0]  ddr_ba;
    logic             issue_valid, busy, err_illegal;

    issue_fifo_drain dut (
        .clk(clk), .rst_n(rst_n), .issue_en(issue_en), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_ren(fifo_ren),
        .ddr_cs_n(ddr_cs_n), .ddr_ras_n(ddr_ras_n), .ddr_cas_n(ddr_cas_n), .ddr_we_n(ddr_we_n),
        .ddr_addr(ddr_addr), .ddr_ba(ddr_ba), .issue_valid(issue_valid),
        .busy(busy), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] q[$];
    int  cyc = 0;
    int  next_ok = 0;
    int  pops = 0;
    int  issues = 0;
    logic [3:0]       exp_pins = 4'b0111;
    logic [ROW_W-1:0] exp_addr = '0;
    logic [BA_W-1:0]  exp_ba = '0;
    logic             exp_valid = 1'b0;
    logic             exp_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push(input int cmd, input int row, input int col, input int bank);
        logic [DW-1:0] e;
        e = {CMD_W'(cmd), ROW_W'(row), COL_W'(col), BA_W'(bank)};
        q.push_back(e);
    endtask

    // Outcome of issuing one entry: the pins it produces and the spacing to the next issue.
    task automatic model_issue(input logic [DW-1:0] e);
        int cmd, row, col, bank, spacing;
        cmd  = int'(e[DW-1 -: CMD_W]);
        row  = int'(e[BA_W+COL_W +: ROW_W]);
        col  = int'(e[BA_W +: COL_W]);
        bank = int'(e[BA_W-1:0]);
        exp_pins = 4'b0111; exp_addr = '0; exp_ba = '0; exp_valid = 1'b0; spacing = 1;
        case (cmd)
            0: ;
            1: begin exp_pins = 4'b0011; exp_addr = ROW_W'(row); exp_ba = BA_W'(bank); exp_valid = 1; spacing = 4; end
            2: begin exp_pins = 4'b0101; exp_addr = ROW_W'(col % 1024) & ~ROW_W'(1024); exp_ba = BA_W'(bank); exp_valid = 1; spacing = 2; end
            3: begin exp_pins = 4'b0100; exp_addr = ROW_W'(col % 1024) & ~ROW_W'(1024); exp_ba = BA_W'(bank); exp_valid = 1; spacing = 2; end
            4: begin exp_pins = 4'b0010; exp_ba = BA_W'(bank); exp_valid = 1; spacing = 4; end
            5: begin exp_pins = 4'b0001; exp_valid = 1; spacing = 40; end
            default: exp_err = 1'b1;
        endcase
        next_ok = cyc + spacing;
    endtask

    // One clock cycle: entered and left just after a falling edge.
    task automatic step();
        logic pop;
        if (q.size() > 0) begin
            fifo_empty = 1'b0;
            fifo_data  = q[0];
        end else begin
            fifo_empty = 1'b1;
            fifo_data  = DW'($urandom);
        end
        #1;
        pop = issue_en && (q.size() > 0) && (cyc >= next_ok);
        check("fifo_ren", 32'(fifo_ren), 32'(pop));
        check("busy", 32'(busy), 32'(cyc < next_ok));
        if (pop) begin
            model_issue(q[0]);
            void'(q.pop_front());
            pops++;
        end else begin
            exp_pins = 4'b0111; exp_addr = '0; exp_ba = '0; exp_valid = 1'b0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check("pins", 32'({ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n}), 32'(exp_pins));
        check("ddr_addr", 32'(ddr_addr), 32'(exp_addr));
        check("ddr_ba", 32'(ddr_ba), 32'(exp_ba));
        check("issue_valid", 32'(issue_valid), 32'(exp_valid));
        check("err_illegal", 32'(err_illegal), 32'(exp_err));
        if (issue_valid) issues++;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (q.size() > 0 || cyc < next_ok); i++) step();
        check("drained", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int last_issue, read_cnt, p0;
        repeat (3) @(negedge clk);
        check("reset_pins", 32'({ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n}), 32'h7);
        check("reset_ren", 32'(fifo_ren), 32'd0);
        rst_n = 1'b1;
        issue_en = 1'b1;

        // Empty FIFO: nothing pops, pins idle.
        repeat (10) step();

        // Single ACT, then its spacing.
        push(1, 'h1A5, 0, 2);
        repeat (6) step();

        // ACT followed by READ: READ must land exactly 4 cycles after ACT.
        push(1, 'h1A5, 0, 2);
        push(2, 0, 'h3F, 2);
        last_issue = -1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (issue_valid && ddr_ras_n == 1'b0) last_issue = cyc;
            if (issue_valid && ddr_ras_n == 1'b1 && ddr_cas_n == 1'b0)
                check("act_to_read", 32'(cyc - last_issue), 32'd4);
        end

        // Four READs at tCCD spacing.
        p0 = pops;
        read_cnt = 0;
        for (int i = 0; i < 4; i++) push(2, 0, i * 8 + 1, i);
        for (int i = 0; i < 10; i++) begin
            step();
            if (issue_valid) read_cnt++;
        end
        check("four_reads_pops", 32'(pops - p0), 32'd4);
        check("four_reads_issued", 32'(read_cnt), 32'd4);
        check("four_reads_empty", 32'(q.size()), 32'd0);

        // Illegal code then REF, then an ACT that must wait out the REF gap.
        push(9, 'h3FFF, 'h3FF, 7);
        push(5, 0, 0, 0);
        push(1, 'h55, 0, 1);
        repeat (20) step();

        // Reset in the middle of the REF gap discards the remaining spacing.
        rst_n = 1'b0;
        #1;
        check("rst_pins", 32'({ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n}), 32'h7);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ren", 32'(fifo_ren), 32'd0);
        check("rst_err", 32'(err_illegal), 32'd0);
        check("rst_valid", 32'(issue_valid), 32'd0);
        @(posedge clk); cyc++; @(negedge clk);
        rst_n = 1'b1;
        exp_err = 1'b0;
        next_ok = cyc;
        step();
        check("post_rst_act", 32'(issue_valid), 32'd1);
        drain(60);

        // Random traffic with random issue_en stalls.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 35 && q.size() < 8) begin
                int c;
                c = ($urandom_range(0, 19) == 0) ? $urandom_range(6, 15) : $urandom_range(0, 5);
                if (c == 5 && $urandom_range(0, 3) != 0) c = 2;
                push(c, $urandom_range(0, 16383), $urandom_range(0, 1023), $urandom_range(0, 7));
            end
            issue_en = ($urandom_range(0, 99) < 80);
            step();
        end
        issue_en = 1'b1;
        drain(500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/issue_fifo_drain.md
Name: issue_fifo_drain

Overview:
- Consumer side of the issue FIFO: pops scheduled {command, addr, bank} entries and drives the DDR command/address bus.
- Enforces a minimum per-command spacing so every issued command respects its DRAM timing constraint.
- Sits between the issue FIFO read port and the DDR PHY command pins.
- Emits exactly one DRAM command per pop; every other cycle drives NOP.

Parameters:
- ROW_W, 14, row address bits; also the ddr_addr width.
- COL_W, 10, column address bits (COL_W <= ROW_W).
- BA_W, 3, bank address bits.
- CMD_W, 4, command field width.
- GAP_ACT, 4, cycles from ACT to next issue (tRCD), >=1.
- GAP_RW, 2, cycles from READ/WRITE to next issue (tCCD), >=1.
- GAP_PRE, 4, cycles from PRE to next issue (tRP), >=1.
- GAP_REF, 40, cycles from REF to next issue (tRFC), >=1, <=63.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- issue_en  in  1  drain enable; 0 stalls popping (e.g. during init)
- fifo_empty  in  1  issue FIFO empty flag
- fifo_data  in  CMD_W+COL_W+ROW_W+BA_W  head entry {command, addr, bank}; addr is {row, col}, row in the upper ROW_W bits
- fifo_ren  out  1  pop request, combinational, one cycle per accepted entry
- ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n  out  1 each  registered DDR command pins
- ddr_addr  out  ROW_W  registered address
- ddr_ba  out  BA_W  registered bank
- issue_valid  out  1  registered; high in the cycle a non-NOP command is on the pins
- busy  out  1  gap counter nonzero
- err_illegal  out  1  sticky; set on an undefined command code

Behaviour:
- Command codes: 0 NOP, 1 ACT, 2 READ, 3 WRITE, 4 PRE, 5 REF. Codes 6..15 are illegal.
- Pin encoding {cs_n, ras_n, cas_n, we_n}:
  - NOP 0111, ACT 0011, READ 0101, WRITE 0100, PRE 0010, REF 0001.
- Address driven per command:
  - ACT: ddr_addr = row.
  - READ/WRITE: ddr_addr = zero-extended col, with A10 forced 0.
  - PRE: ddr_addr = 0 (single bank, A10 = 0).
  - REF and NOP: ddr_addr = 0, ddr_ba = 0.
  - All other commands: ddr_ba = bank.
- Reset (async assert): all pins take NOP encoding, ddr_addr = 0, ddr_ba = 0.
  - issue_valid = 0, err_illegal = 0, gap counter = 0.
  - fifo_ren is 0 while rst_n is low.
  - Reset mid-gap or mid-issue discards the in-flight command; no partial command appears on the pins.
- State: IDLE (gap = 0) and GAP (gap != 0); busy = (state == GAP).
- Pop condition, evaluated in cycle N: fifo_ren = issue_en & ~fifo_empty & (gap == 0).
- On the edge ending cycle N when fifo_ren = 1:
  - Pins are registered from fifo_data, so the command is visible for exactly cycle N+1.
  - issue_valid = 1 for a legal non-NOP command.
  - gap loads GAP_x - 1, where GAP_x is the spacing for that command. A NOP entry uses GAP 1, i.e. gap loads 0.
- In any cycle without a pop: pins return to NOP, issue_valid = 0, gap decrements toward 0 and saturates at 0.
- Result: two successive issues are exactly GAP_x cycles apart when the FIFO is non-empty. GAP_x = 1 gives back-to-back issue every cycle.
- Illegal code:
  - The entry is still popped and drives NOP on the pins; issue_valid = 0; gap loads 0.
  - err_illegal sets and holds until reset.
- fifo_empty = 1 or issue_en = 0: no pop; the gap counter keeps counting down.
  - Dropping issue_en never cancels an issued command or shortens the gap.
- No pop is ever issued with fifo_empty = 1.
- Exactly one pop per issued command; fifo_data is sampled only at the popping edge.

Test Plan:
- Reset, then FIFO empty for 10 cycles -> fifo_ren = 0 throughout; pins 0111, addr/ba 0, issue_valid 0.
- Push ACT row 0x1A5 bank 2 -> fifo_ren high for 1 cycle; next cycle pins 0011, ddr_addr 0x1A5, ddr_ba 2, issue_valid 1; then NOP; busy high for 3 cycles.
- Push ACT then READ col 0x3F bank 2 back-to-back -> READ appears exactly 4 cycles after ACT; ddr_addr 0x03F, pins 0101.
- Push four READs with GAP_RW = 2 -> READs on the pins every 2nd cycle; 4 pops total; FIFO ends empty.
- Push code 9 then REF -> code 9 gives a NOP cycle with issue_valid 0 and err_illegal set; REF (0001) issues the next cycle; the next entry waits 40 cycles; err_illegal stays 1.
- Assert rst_n low during the REF gap -> pins NOP, busy 0 immediately; after release, a queued ACT issues without waiting for the remainder of the old gap.
